// File: rtl/axil_req_master.sv
// Single-outstanding AXI4-Lite initiator: converts a simple request/response
// client port into AXI4-Lite master transactions, returning rdata and resp.
module axil_req_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [STRB_WIDTH-1:0] req_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_WR_ADDR_DATA = 3'd1,
    S_WR_RESP      = 3'd2,
    S_RD_ADDR      = 3'd3,
    S_RD_DATA      = 3'd4,
    S_RESP         = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  arvalid_q, arvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            resp_q, resp_d;

  // Next-state and datapath decode
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          if (req_we) begin
            state_d   = S_WR_ADDR_DATA;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = S_RD_ADDR;
            arvalid_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR_ADDR_DATA: begin
        // AW and W retire independently; leave once both have handshaken
        if (awvalid_q && m_axil_awready) begin
          awvalid_d = 1'b0;
        end else begin
          awvalid_d = awvalid_q;
        end
        if (wvalid_q && m_axil_wready) begin
          wvalid_d = 1'b0;
        end else begin
          wvalid_d = wvalid_q;
        end
        if (!awvalid_d && !wvalid_d) begin
          state_d = S_WR_RESP;
        end else begin
          state_d = S_WR_ADDR_DATA;
        end
      end
      S_WR_RESP: begin
        if (m_axil_bvalid) begin
          resp_d  = m_axil_bresp;
          state_d = S_RESP;
        end else begin
          state_d = S_WR_RESP;
        end
      end
      S_RD_ADDR: begin
        if (m_axil_arready) begin
          arvalid_d = 1'b0;
          state_d   = S_RD_DATA;
        end else begin
          state_d = S_RD_ADDR;
        end
      end
      S_RD_DATA: begin
        if (m_axil_rvalid) begin
          rdata_d = m_axil_rdata;
          resp_d  = m_axil_rresp;
          state_d = S_RESP;
        end else begin
          state_d = S_RD_DATA;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d   = S_IDLE;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        arvalid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= {ADDR_WIDTH{1'b0}};
      wdata_q   <= {DATA_WIDTH{1'b0}};
      wstrb_q   <= {STRB_WIDTH{1'b0}};
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rdata_q   <= {DATA_WIDTH{1'b0}};
      resp_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
    end
  end

  // Readies are decoded from registered state only, never from AXI inputs
  assign req_ready      = (state_q == S_IDLE) && !rst;
  assign rsp_valid      = (state_q == S_RESP);
  assign rsp_rdata      = rdata_q;
  assign rsp_resp       = resp_q;
  assign m_axil_awaddr  = addr_q;
  assign m_axil_awprot  = 3'b000;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = wstrb_q;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_bready  = (state_q == S_WR_RESP);
  assign m_axil_araddr  = addr_q;
  assign m_axil_arprot  = 3'b000;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_rready  = (state_q == S_RD_DATA);

endmodule
